// File: rtl/led_mode_sequencer.sv
// Button-driven lighting mode controller: debounces one key and produces R/G/B duty words
// for off, static white, breathing white and colour-wheel modes.
module led_mode_sequencer #(
  parameter int unsigned STEP_DIV = 46875,
  parameter int unsigned DEBOUNCE = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_in,
  output logic [7:0] duty_r,
  output logic [7:0] duty_g,
  output logic [7:0] duty_b,
  output logic [1:0] mode,
  output logic       step_tick
);

  localparam int unsigned DebW  = $clog2(DEBOUNCE);
  localparam int unsigned StepW = $clog2(STEP_DIV);
  localparam logic [DebW-1:0]  DebMax  = DebW'(DEBOUNCE - 1);
  localparam logic [StepW-1:0] StepMax = StepW'(STEP_DIV - 1);

  localparam logic [1:0] ModeOff     = 2'd0;
  localparam logic [1:0] ModeWhite   = 2'd1;
  localparam logic [1:0] ModeBreath  = 2'd2;
  localparam logic [1:0] ModeRainbow = 2'd3;

  logic            key_meta_q, key_sync_q, key_lvl_q, key_prev_q;
  logic [DebW-1:0] deb_cnt_q;
  logic            press;

  logic [StepW-1:0] step_cnt_q;
  logic             step_tick_q;

  logic [1:0] mode_q, mode_d;
  logic [7:0] env_q, env_d;
  logic       dir_q, dir_d;  // 0 = rising, 1 = falling
  logic [7:0] ramp_q, ramp_d;
  logic [1:0] phase_q, phase_d;

  logic [7:0] duty_r_q, duty_g_q, duty_b_q;
  logic [7:0] duty_r_d, duty_g_d, duty_b_d;

  // Counter runs only while the synchronized level disagrees with the accepted one.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_meta_q <= 1'b0;
      key_sync_q <= 1'b0;
      key_lvl_q  <= 1'b0;
      key_prev_q <= 1'b0;
      deb_cnt_q  <= '0;
    end else begin
      key_meta_q <= key_in;
      key_sync_q <= key_meta_q;
      key_prev_q <= key_lvl_q;
      if (key_sync_q == key_lvl_q) begin
        deb_cnt_q <= '0;
      end else if (deb_cnt_q == DebMax) begin
        key_lvl_q <= key_sync_q;
        deb_cnt_q <= '0;
      end else begin
        deb_cnt_q <= deb_cnt_q + DebW'(1);
      end
    end
  end

  assign press = key_lvl_q & ~key_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      step_cnt_q  <= '0;
      step_tick_q <= 1'b0;
    end else if (step_cnt_q == StepMax) begin
      step_cnt_q  <= '0;
      step_tick_q <= 1'b1;
    end else begin
      step_cnt_q  <= step_cnt_q + StepW'(1);
      step_tick_q <= 1'b0;
    end
  end

  // A press takes priority over a coincident step and restarts the working state.
  always_comb begin
    mode_d  = mode_q;
    env_d   = env_q;
    dir_d   = dir_q;
    ramp_d  = ramp_q;
    phase_d = phase_q;
    if (press) begin
      mode_d  = mode_q + 2'd1;
      env_d   = '0;
      dir_d   = 1'b0;
      ramp_d  = '0;
      phase_d = '0;
    end else if (step_tick_q) begin
      unique case (mode_q)
        ModeBreath: begin
          if (!dir_q) begin
            env_d = env_q + 8'd1;
            if (env_d == 8'hFF) dir_d = 1'b1;
          end else begin
            env_d = env_q - 8'd1;
            if (env_d == 8'h00) dir_d = 1'b0;
          end
        end
        ModeRainbow: begin
          ramp_d = ramp_q + 8'd1;
          if (ramp_q == 8'hFF) phase_d = (phase_q == 2'd2) ? 2'd0 : phase_q + 2'd1;
        end
        ModeOff, ModeWhite: ;
      endcase
    end
  end

  // Duties follow the registered mode but the freshly stepped envelope/wheel position.
  always_comb begin
    duty_r_d = 8'h00;
    duty_g_d = 8'h00;
    duty_b_d = 8'h00;
    unique case (mode_q)
      ModeOff: ;
      ModeWhite: begin
        duty_r_d = 8'hFF;
        duty_g_d = 8'hFF;
        duty_b_d = 8'hFF;
      end
      ModeBreath: begin
        duty_r_d = env_d;
        duty_g_d = env_d;
        duty_b_d = env_d;
      end
      ModeRainbow: begin
        case (phase_d)
          2'd0: begin
            duty_r_d = ~ramp_d;
            duty_g_d = ramp_d;
          end
          2'd1: begin
            duty_g_d = ~ramp_d;
            duty_b_d = ramp_d;
          end
          default: begin
            duty_b_d = ~ramp_d;
            duty_r_d = ramp_d;
          end
        endcase
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q   <= ModeOff;
      env_q    <= '0;
      dir_q    <= 1'b0;
      ramp_q   <= '0;
      phase_q  <= '0;
      duty_r_q <= '0;
      duty_g_q <= '0;
      duty_b_q <= '0;
    end else begin
      mode_q   <= mode_d;
      env_q    <= env_d;
      dir_q    <= dir_d;
      ramp_q   <= ramp_d;
      phase_q  <= phase_d;
      duty_r_q <= duty_r_d;
      duty_g_q <= duty_g_d;
      duty_b_q <= duty_b_d;
    end
  end

  assign duty_r    = duty_r_q;
  assign duty_g    = duty_g_q;
  assign duty_b    = duty_b_q;
  assign mode      = mode_q;
  assign step_tick = step_tick_q;

endmodule

// File: tb/tb_led_mode_sequencer.sv
// Bench for led_mode_sequencer: directed walk through the mode list plus random key/reset
// traffic, all checked every cycle against a tick-count model of the lighting modes.
module tb_led_mode_sequencer;

  localparam int S = 4;
  localparam int D = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_in = 1'b0;
  logic [7:0] duty_r, duty_g, duty_b;
  logic [1:0] mode;
  logic       step_tick;

  int n_checks = 0;
  int n_fail = 0;

  led_mode_sequencer #(.STEP_DIV(S), .DEBOUNCE(D)) dut (
    .clk(clk), .rst(rst), .key_in(key_in),
    .duty_r(duty_r), .duty_g(duty_g), .duty_b(duty_b),
    .mode(mode), .step_tick(step_tick)
  );

  always #5 clk = ~clk;

  // Model: mode plus number of steps applied since entering it; colours derived from that.
  int        m_k, m_run, m_mode, m_prev_mode, m_n;
  bit        m_s1, m_s2, m_acc, m_acc_prev, m_tick;
  logic [23:0] m_exp;

  function automatic logic [23:0] duty_of(input int md, input int n);
    int p, e, ph, rm;
    case (md)
      0: return 24'h000000;
      1: return 24'hFFFFFF;
      2: begin
        p = n % 510;
        e = (p <= 255) ? p : 510 - p;
        return {8'(e), 8'(e), 8'(e)};
      end
      default: begin
        ph = (n / 256) % 3;
        rm = n % 256;
        if (ph == 0) return {8'(255 - rm), 8'(rm), 8'h00};
        if (ph == 1) return {8'h00, 8'(255 - rm), 8'(rm)};
        return {8'(rm), 8'h00, 8'(255 - rm)};
      end
    endcase
  endfunction

  task automatic model_step(input bit r, input bit key);
    bit press, tick;
    if (r) begin
      m_k = 0; m_run = 0; m_mode = 0; m_prev_mode = 0; m_n = 0;
      m_s1 = 0; m_s2 = 0; m_acc = 0; m_acc_prev = 0; m_tick = 0;
      m_exp = 24'h0;
      return;
    end
    press = m_acc && !m_acc_prev;
    tick = m_tick;
    m_prev_mode = m_mode;
    if (press) begin
      m_mode = (m_mode + 1) % 4;
      m_n = 0;
    end else if (tick && m_mode >= 2) begin
      m_n++;
    end
    m_exp = duty_of(m_prev_mode, m_n);
    m_acc_prev = m_acc;
    if (m_s2 != m_acc) begin
      m_run++;
      if (m_run == D) begin
        m_acc = m_s2;
        m_run = 0;
      end
    end else begin
      m_run = 0;
    end
    m_s2 = m_s1;
    m_s1 = key;
    m_k++;
    m_tick = (m_k % S == 0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always begin
    @(posedge clk);
    model_step(rst, key_in);
    #1;
    chk("mode", 32'(mode), 32'(m_mode));
    chk("duty_r", 32'(duty_r), 32'(m_exp[23:16]));
    chk("duty_g", 32'(duty_g), 32'(m_exp[15:8]));
    chk("duty_b", 32'(duty_b), 32'(m_exp[7:0]));
    chk("step_tick", 32'(step_tick), 32'(m_tick));
    if (m_mode == 3 && m_prev_mode == 3)
      chk("rgb_sum", 32'(duty_r) + 32'(duty_g) + 32'(duty_b), 32'd255);
  end

  task automatic lit_rgb(input string name, input logic [23:0] exp);
    chk(name, {8'h0, duty_r, duty_g, duty_b}, {8'h0, exp});
  endtask

  task automatic press_key(input int hold);
    key_in = 1'b1;
    repeat (hold) @(negedge clk);
    key_in = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic wait_state(input int md, input int n);
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (m_mode == md && m_n == n) return;
    end
    n_fail++;
    $display("FAIL wait_state: timeout waiting for mode %0d step %0d", md, n);
  endtask

  initial begin
    int exp_seq[4] = '{3, 0, 1, 2};

    repeat (3) @(negedge clk);
    chk("reset_mode", 32'(mode), 32'd0);
    lit_rgb("reset_duty", 24'h000000);
    chk("reset_tick", 32'(step_tick), 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("idle_mode", 32'(mode), 32'd0);
    lit_rgb("idle_duty", 24'h000000);

    press_key(5);
    chk("glitch_mode", 32'(mode), 32'd0);

    press_key(20);
    chk("white_mode", 32'(mode), 32'd1);
    lit_rgb("white_duty", 24'hFFFFFF);

    key_in = 1'b1;
    repeat (1000) @(negedge clk);
    chk("hold_mode", 32'(mode), 32'd2);
    key_in = 1'b0;
    repeat (20) @(negedge clk);
    chk("hold_release_mode", 32'(mode), 32'd2);

    foreach (exp_seq[i]) begin
      press_key(12);
      chk("press_seq", 32'(mode), 32'(exp_seq[i]));
    end

    wait_state(2, 255); lit_rgb("breath_255", 24'hFFFFFF);
    wait_state(2, 256); lit_rgb("breath_256", 24'hFEFEFE);
    wait_state(2, 510); lit_rgb("breath_510", 24'h000000);
    wait_state(2, 511); lit_rgb("breath_511", 24'h010101);

    key_in = 1'b1;
    wait_state(3, 1); lit_rgb("rainbow_1", 24'hFE0100);
    key_in = 1'b0;
    wait_state(3, 256); lit_rgb("rainbow_256", 24'h00FF00);
    wait_state(3, 768); lit_rgb("rainbow_768", 24'hFF0000);

    press_key(12);
    press_key(12);
    press_key(12);
    chk("pre_collide_mode", 32'(mode), 32'd2);
    // Launch the key so its press lands in the same cycle as a step with env at 0x40.
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (m_mode == 2 && m_n == 8'h3E && (m_k + D + 2) % S == 0) break;
    end
    key_in = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (m_acc && !m_acc_prev) break;
    end
    chk("collide_tick", 32'(step_tick), 32'd1);
    lit_rgb("collide_env", 24'h404040);
    @(negedge clk);
    chk("collide_mode", 32'(mode), 32'd3);
    @(negedge clk);
    lit_rgb("collide_rgb", 24'hFF0000);
    key_in = 1'b0;
    repeat (20) @(negedge clk);

    wait_state(3, 530);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_mode", 32'(mode), 32'd0);
    lit_rgb("midrst_duty", 24'h000000);
    chk("midrst_tick", 32'(step_tick), 32'd0);
    rst = 1'b0;
    press_key(12);
    chk("after_rst_mode", 32'(mode), 32'd1);

    for (int i = 0; i < 60; i++) begin
      key_in = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat ($urandom_range(1, 30)) @(negedge clk);
    end
    key_in = 1'b0;
    repeat (30) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
